// File: rtl/compressor_4to2.sv
// Registered 4:2 compressor. Each column folds x1..x3 in a full adder, then folds
// that sum with x4 and the neighbouring column's majority carry in a second full adder.
module compressor_4to2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout,
  output logic             out_valid
);

  // Handshake: in_valid qualifies x1..x4/cin on the sampling edge; there is no
  // ready, so every qualified cycle is accepted. out_valid is high for exactly one
  // cycle per accepted input, one clock later; outputs hold when nothing is accepted.

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_co;
  logic [WIDTH:0]   w_cin_chain;
  logic [WIDTH-1:0] w_cin;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             w_cout;

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic             r_cout;
  logic             r_out_valid;

  assign w_s1 = x1 ^ x2 ^ x3;
  assign w_co = (x1 & x2) | (x1 & x3) | (x2 & x3);

  // Shifting co up by one column keeps the carry chain one column deep;
  // the bit that falls off the top becomes cout.
  assign w_cin_chain = {w_co, cin};
  assign w_cin       = w_cin_chain[WIDTH-1:0];
  assign w_cout      = w_cin_chain[WIDTH];

  assign w_sum   = w_s1 ^ x4 ^ w_cin;
  assign w_carry = (w_s1 & x4) | (w_s1 & w_cin) | (x4 & w_cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
        r_cout  <= w_cout;
      end
    end
  end

  assign sum       = r_sum;
  assign carry     = r_carry;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_compressor_4to2.sv
// Directed bench for compressor_4to2 at WIDTH=1 and WIDTH=8 sharing clock and control.
module tb_compressor_4to2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;
  logic cin;

  logic a_x1, a_x2, a_x3, a_x4;
  logic a_sum, a_carry, a_cout, a_ov;

  logic [7:0] b_x1, b_x2, b_x3, b_x4;
  logic [7:0] b_sum, b_carry;
  logic       b_cout, b_ov;

  int n_checks = 0;
  int n_fail   = 0;

  compressor_4to2 #(.WIDTH(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x1(a_x1), .x2(a_x2), .x3(a_x3), .x4(a_x4), .cin(cin),
    .sum(a_sum), .carry(a_carry), .cout(a_cout), .out_valid(a_ov)
  );

  compressor_4to2 #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x1(b_x1), .x2(b_x2), .x3(b_x3), .x4(b_x4), .cin(cin),
    .sum(b_sum), .carry(b_carry), .cout(b_cout), .out_valid(b_ov)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: inputs change 1 time unit after an edge, outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] bits);
    in_valid = v;
    {a_x1, a_x2, a_x3, a_x4, cin} = bits;
    tick();
  endtask

  task automatic drive_b(input logic v, input logic [7:0] p, q, r, s, input logic c);
    in_valid = v;
    b_x1 = p; b_x2 = q; b_x3 = r; b_x4 = s; cin = c;
    tick();
  endtask

  // reference for one column: {sum, carry, cout}
  function automatic logic [2:0] ref1(input logic [4:0] bits);
    logic x1, x2, x3, x4, c, s1, co;
    {x1, x2, x3, x4, c} = bits;
    s1 = x1 ^ x2 ^ x3;
    co = (x1 & x2) | (x1 & x3) | (x2 & x3);
    return {s1 ^ x4 ^ c, (s1 & x4) | (s1 & c) | (x4 & c), co};
  endfunction

  // scoreboard-style check of the W=1 instance against the column reference and the sum invariant
  task automatic check_a(input string tag, input logic [4:0] bits);
    logic [2:0] e;
    int total;
    e = ref1(bits);
    total = int'(bits[4]) + int'(bits[3]) + int'(bits[2]) + int'(bits[1]) + int'(bits[0]);
    chk({tag, "_sum"},   32'(a_sum),   32'(e[2]));
    chk({tag, "_carry"}, 32'(a_carry), 32'(e[1]));
    chk({tag, "_cout"},  32'(a_cout),  32'(e[0]));
    chk({tag, "_inv"},   32'(int'(a_sum) + 2 * int'(a_carry) + 2 * int'(a_cout)), 32'(total));
    chk({tag, "_ov"},    32'(a_ov),    32'd1);
  endtask

  initial begin
    logic [4:0] g;
    logic [7:0] p, q, r, s;
    logic       c;
    int         exp_total;

    rst = 1'b1; in_valid = 1'b0; cin = 1'b0;
    {a_x1, a_x2, a_x3, a_x4} = 4'b0;
    b_x1 = 8'h0; b_x2 = 8'h0; b_x3 = 8'h0; b_x4 = 8'h0;
    tick();
    tick();
    chk("rst_a_sum",   32'(a_sum),   32'd0);
    chk("rst_a_carry", 32'(a_carry), 32'd0);
    chk("rst_a_cout",  32'(a_cout),  32'd0);
    chk("rst_a_ov",    32'(a_ov),    32'd0);
    chk("rst_b_sum",   32'(b_sum),   32'd0);
    chk("rst_b_carry", 32'(b_carry), 32'd0);
    chk("rst_b_ov",    32'(b_ov),    32'd0);
    rst = 1'b0;

    // first capture right after reset release: x1 only
    drive_a(1'b1, 5'b10000);
    chk("x1_only_sum",   32'(a_sum),   32'd1);
    chk("x1_only_carry", 32'(a_carry), 32'd0);
    chk("x1_only_cout",  32'(a_cout),  32'd0);
    chk("x1_only_ov",    32'(a_ov),    32'd1);

    drive_a(1'b1, 5'b11000);
    chk("x1x2_sum",   32'(a_sum),   32'd0);
    chk("x1x2_carry", 32'(a_carry), 32'd0);
    chk("x1x2_cout",  32'(a_cout),  32'd1);

    drive_a(1'b1, 5'b11111);
    chk("all1_sum",   32'(a_sum),   32'd1);
    chk("all1_carry", 32'(a_carry), 32'd1);
    chk("all1_cout",  32'(a_cout),  32'd1);

    // Gray-code walk over all 32 combinations, one input flips per cycle
    for (int i = 0; i < 32; i++) begin
      g = 5'(i) ^ (5'(i) >> 1);
      drive_a(1'b1, g);
      check_a("walk", g);
    end

    // valid pattern 1,0,1 with outputs holding during the gap
    drive_a(1'b1, 5'b10100);
    check_a("pat1", 5'b10100);
    drive_a(1'b0, 5'b01011);
    chk("gap_sum",   32'(a_sum),   32'd0);
    chk("gap_carry", 32'(a_carry), 32'd0);
    chk("gap_cout",  32'(a_cout),  32'd1);
    chk("gap_ov",    32'(a_ov),    32'd0);
    drive_a(1'b1, 5'b01011);
    check_a("pat3", 5'b01011);

    // WIDTH=8 saturated corner
    drive_b(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    chk("ff_sum",   32'(b_sum),   32'h0FF);
    chk("ff_carry", 32'(b_carry), 32'h0FF);
    chk("ff_cout",  32'(b_cout),  32'd1);
    chk("ff_total", 32'(int'(b_sum) + 2 * int'(b_carry) + 256 * int'(b_cout)), 32'd1021);
    chk("ff_ov",    32'(b_ov),    32'd1);

    // reset wins over valid with nonzero inputs
    rst = 1'b1;
    drive_b(1'b1, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 1'b1);
    chk("rstv_sum",   32'(b_sum),   32'd0);
    chk("rstv_carry", 32'(b_carry), 32'd0);
    chk("rstv_cout",  32'(b_cout),  32'd0);
    chk("rstv_ov",    32'(b_ov),    32'd0);
    rst = 1'b0;
    // 0x12+0x34+0x56+0x78+1 = 0x115 = 277
    drive_b(1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
    chk("post_rst_total", 32'(int'(b_sum) + 2 * int'(b_carry) + 256 * int'(b_cout)), 32'd277);
    chk("post_rst_ov",    32'(b_ov), 32'd1);

    // back-to-back random vectors against the arithmetic invariant
    for (int i = 0; i < 1000; i++) begin
      p = 8'($urandom_range(0, 255));
      q = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      exp_total = int'(p) + int'(q) + int'(r) + int'(s) + int'(c);
      drive_b(1'b1, p, q, r, s, c);
      chk("rand_total", 32'(int'(b_sum) + 2 * int'(b_carry) + 256 * int'(b_cout)), 32'(exp_total));
      chk("rand_ov",    32'(b_ov), 32'd1);
    end

    in_valid = 1'b0;
    tick();
    chk("idle_ov", 32'(b_ov), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
